// File: rtl/cache_arb_pkg.sv
// Shared types and geometry helpers for the L1 miss arbiter.
// Round-robin arbitration between the I-cache and D-cache is enabled by
// defining ARB_ROUND_ROBIN_EN; otherwise the D-cache has fixed priority.
package cache_arb_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_WB_REQ  = 3'd1,
        ARB_WB_DATA = 3'd2,
        ARB_RD_REQ  = 3'd3,
        ARB_RD_DATA = 3'd4
    } l1_arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Number of L2 beats that make up one cache block.
    function automatic int calc_beats(input int block_bytes, input int data_w);
        return block_bytes / (data_w / 8);
    endfunction

    // Width of the byte offset inside a block.
    function automatic int calc_off_w(input int block_bytes);
        return $clog2(block_bytes);
    endfunction

    // Width of a beat index; never narrower than one bit.
    function automatic int calc_beat_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/l1_miss_arbiter_if.sv
// Bundle of the L1 miss, D-cache data-store and L2 port signals.
// master = the arbiter, slave = the surrounding caches.
interface l1_miss_arbiter_if
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BLOCK_BYTES = 128
);
    localparam int BEAT_W = calc_beat_w(calc_beats(BLOCK_BYTES, DATA_W));

    // I-cache miss / refill
    logic              i_req_valid;
    logic              i_req_ready;
    logic [ADDR_W-1:0] i_req_addr;
    logic              i_rsp_valid;
    logic [DATA_W-1:0] i_rsp_data;
    logic              i_rsp_last;

    // D-cache miss / victim read / refill
    logic              d_req_valid;
    logic              d_req_ready;
    logic [ADDR_W-1:0] d_req_addr;
    logic              d_req_wb;
    logic [ADDR_W-1:0] d_req_wb_addr;
    logic              d_wb_rd;
    logic [BEAT_W-1:0] d_wb_beat;
    logic [DATA_W-1:0] d_wb_data;
    logic              d_rsp_valid;
    logic [DATA_W-1:0] d_rsp_data;
    logic              d_rsp_last;

    // L2 port
    logic              l2_req_valid;
    logic              l2_req_ready;
    logic              l2_req_write;
    logic [ADDR_W-1:0] l2_req_addr;
    logic              l2_wdata_valid;
    logic              l2_wdata_ready;
    logic [DATA_W-1:0] l2_wdata;
    logic              l2_wdata_last;
    logic              l2_rdata_valid;
    logic [DATA_W-1:0] l2_rdata;

    modport master (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_last,
        input  d_req_valid, d_req_addr, d_req_wb, d_req_wb_addr, d_wb_data,
        output d_req_ready, d_wb_rd, d_wb_beat, d_rsp_valid, d_rsp_data, d_rsp_last,
        input  l2_req_ready, l2_wdata_ready, l2_rdata_valid, l2_rdata,
        output l2_req_valid, l2_req_write, l2_req_addr,
        output l2_wdata_valid, l2_wdata, l2_wdata_last
    );

    modport slave (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_last,
        output d_req_valid, d_req_addr, d_req_wb, d_req_wb_addr, d_wb_data,
        input  d_req_ready, d_wb_rd, d_wb_beat, d_rsp_valid, d_rsp_data, d_rsp_last,
        output l2_req_ready, l2_wdata_ready, l2_rdata_valid, l2_rdata,
        input  l2_req_valid, l2_req_write, l2_req_addr,
        input  l2_wdata_valid, l2_wdata, l2_wdata_last
    );

endinterface

// File: rtl/l1_wb_streamer.sv
// Streams a dirty victim block from the D-cache data store to L2.
// The data store answers one cycle after a read strobe; if L2 stalls the
// beat that is arriving, it is parked in a hold register so the store
// never has to be re-read and the presented beat stays stable.
module l1_wb_streamer
    import cache_arb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int BLOCK_BYTES = 128,
    parameter int BEAT_W      = calc_beat_w(calc_beats(BLOCK_BYTES, DATA_W))
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,          // L2 accepted the write request
    input  logic              active_i,         // arbiter is in the data phase
    input  logic              l2_wdata_ready_i,
    input  logic [DATA_W-1:0] d_wb_data_i,
    output logic              d_wb_rd_o,
    output logic [BEAT_W-1:0] d_wb_beat_o,
    output logic              l2_wdata_valid_o,
    output logic [DATA_W-1:0] l2_wdata_o,
    output logic              l2_wdata_last_o,
    output logic              done_o            // last beat handed to L2
);
    localparam int                BEATS     = calc_beats(BLOCK_BYTES, DATA_W);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [BEAT_W-1:0] cnt_q, cnt_d;
    logic              rd_pending_q, rd_pending_d;
    logic              hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              wvalid;
    logic              hs;

    // Beat presentation, store read issue and hold-register capture.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
        cnt_d        = cnt_q;
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;

        wvalid = active_i && (rd_pending_q || hold_valid_q);
        hs     = wvalid && l2_wdata_ready_i;

        d_wb_rd_o    = start_i || (hs && (cnt_q != LAST_BEAT));
        d_wb_beat_o  = '0;
        if (d_wb_rd_o) begin
            d_wb_beat_o = start_i ? '0 : cnt_q + 1'b1;
        end
        rd_pending_d = d_wb_rd_o;

        if (start_i) begin
            cnt_d = '0;
        end else if (hs) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (hs) begin
            hold_valid_d = 1'b0;
        end else if (wvalid && !hold_valid_q) begin
            hold_valid_d = 1'b1;
            hold_d       = d_wb_data_i;
        end

        l2_wdata_valid_o = wvalid;
        l2_wdata_o       = '0;
        if (wvalid) begin
            l2_wdata_o = hold_valid_q ? hold_q : d_wb_data_i;
        end
        l2_wdata_last_o = wvalid && (cnt_q == LAST_BEAT);
        done_o          = hs && (cnt_q == LAST_BEAT);
    end

    // Streamer state registers.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses <= so all registers update from pre-edge values.
        if (!rst) begin
            cnt_q        <= '0;
            rd_pending_q <= 1'b0;
            hold_valid_q <= 1'b0;
            // NOTE: the hold register is a single data word, so it is reset along with its valid flag.
            hold_q       <= '0;
        end else begin
            cnt_q        <= cnt_d;
            rd_pending_q <= rd_pending_d;
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
        end
    end

endmodule

// File: rtl/l1_miss_arbiter.sv
// L1 miss arbiter: shares the single L2 request port between the I-cache
// (refill only) and the D-cache (refill with optional dirty writeback).
// One miss is serviced at a time. Define ARB_ROUND_ROBIN_EN for
// round-robin arbitration; by default the D-cache wins simultaneous misses.
module l1_miss_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BLOCK_BYTES = 128
) (
    input logic               clk,
    input logic               rst,
    l1_miss_arbiter_if.master bus
);
    localparam int                BEATS     = calc_beats(BLOCK_BYTES, DATA_W);
    localparam int                OFF_W     = calc_off_w(BLOCK_BYTES);
    localparam int                BEAT_W    = calc_beat_w(BEATS);
    localparam int                BLK_W     = ADDR_W - OFF_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    localparam logic [2:0] ST_IDLE    = ARB_IDLE;
    localparam logic [2:0] ST_WB_REQ  = ARB_WB_REQ;
    localparam logic [2:0] ST_WB_DATA = ARB_WB_DATA;
    localparam logic [2:0] ST_RD_REQ  = ARB_RD_REQ;
    localparam logic [2:0] ST_RD_DATA = ARB_RD_DATA;

    logic [2:0]        state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [BLK_W-1:0]  miss_blk_q, miss_blk_d;
    logic [BLK_W-1:0]  wb_blk_q, wb_blk_d;
    logic [BEAT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic              grant_i, grant_d;
    logic              wb_done;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t rr_q, rr_d;

    // Round-robin choice on a tie; the pointer flips after every grant.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        rr_d    = rr_q;
        if (state_q == ST_IDLE) begin
            if (bus.d_req_valid && bus.i_req_valid) begin
                grant_d = (rr_q == OWN_D);
                grant_i = (rr_q == OWN_I);
            end else begin
                grant_d = bus.d_req_valid;
                grant_i = bus.i_req_valid;
            end
        end
        if (grant_d) begin
            rr_d = OWN_I;
        end else if (grant_i) begin
            rr_d = OWN_D;
        end
    end

    // Round-robin pointer, pointing at the D-cache out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= OWN_D;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    // Fixed priority: the D-cache always wins a tie.
    always_comb begin
        grant_d = (state_q == ST_IDLE) && bus.d_req_valid;
        grant_i = (state_q == ST_IDLE) && bus.i_req_valid && !bus.d_req_valid;
    end
`endif

    // Miss sequencing: latch the granted miss, then writeback, then refill.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        miss_blk_d = miss_blk_q;
        wb_blk_d   = wb_blk_q;
        rd_cnt_d   = rd_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_d) begin
                    owner_d    = OWN_D;
                    miss_blk_d = bus.d_req_addr[ADDR_W-1:OFF_W];
                    wb_blk_d   = bus.d_req_wb_addr[ADDR_W-1:OFF_W];
                    state_d    = bus.d_req_wb ? ST_WB_REQ : ST_RD_REQ;
                end else if (grant_i) begin
                    owner_d    = OWN_I;
                    miss_blk_d = bus.i_req_addr[ADDR_W-1:OFF_W];
                    state_d    = ST_RD_REQ;
                end
            end
            ST_WB_REQ: begin
                if (bus.l2_req_ready) begin
                    state_d = ST_WB_DATA;
                end
            end
            ST_WB_DATA: begin
                if (wb_done) begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (bus.l2_req_ready) begin
                    state_d  = ST_RD_DATA;
                    rd_cnt_d = '0;
                end
            end
            ST_RD_DATA: begin
                // The local beat count, not L2, decides where the block ends.
                if (bus.l2_rdata_valid) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_I;
            miss_blk_q <= '0;
            wb_blk_q   <= '0;
            rd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            miss_blk_q <= miss_blk_d;
            wb_blk_q   <= wb_blk_d;
            rd_cnt_q   <= rd_cnt_d;
        end
    end

    // Grants, L2 request and same-cycle forwarding of refill beats.
    always_comb begin
        bus.i_req_ready  = grant_i;
        bus.d_req_ready  = grant_d;

        bus.l2_req_valid = (state_q == ST_WB_REQ) || (state_q == ST_RD_REQ);
        bus.l2_req_write = (state_q == ST_WB_REQ);
        bus.l2_req_addr  = '0;
        if (state_q == ST_WB_REQ) begin
            bus.l2_req_addr = {wb_blk_q, {OFF_W{1'b0}}};
        end else if (state_q == ST_RD_REQ) begin
            bus.l2_req_addr = {miss_blk_q, {OFF_W{1'b0}}};
        end

        bus.i_rsp_valid = (state_q == ST_RD_DATA) && bus.l2_rdata_valid && (owner_q == OWN_I);
        bus.d_rsp_valid = (state_q == ST_RD_DATA) && bus.l2_rdata_valid && (owner_q == OWN_D);
        bus.i_rsp_data  = bus.i_rsp_valid ? bus.l2_rdata : '0;
        bus.d_rsp_data  = bus.d_rsp_valid ? bus.l2_rdata : '0;
        bus.i_rsp_last  = bus.i_rsp_valid && (rd_cnt_q == LAST_BEAT);
        bus.d_rsp_last  = bus.d_rsp_valid && (rd_cnt_q == LAST_BEAT);
    end

    l1_wb_streamer #(
        .DATA_W      (DATA_W),
        .BLOCK_BYTES (BLOCK_BYTES),
        .BEAT_W      (BEAT_W)
    ) u_wb_streamer (
        .clk              (clk),
        .rst              (rst),
        .start_i          ((state_q == ST_WB_REQ) && bus.l2_req_ready),
        .active_i         (state_q == ST_WB_DATA),
        .l2_wdata_ready_i (bus.l2_wdata_ready),
        .d_wb_data_i      (bus.d_wb_data),
        .d_wb_rd_o        (bus.d_wb_rd),
        .d_wb_beat_o      (bus.d_wb_beat),
        .l2_wdata_valid_o (bus.l2_wdata_valid),
        .l2_wdata_o       (bus.l2_wdata),
        .l2_wdata_last_o  (bus.l2_wdata_last),
        .done_o           (wb_done)
    );

endmodule

// File: tb/tb_l1_miss_arbiter.sv
// Self-checking bench for l1_miss_arbiter. Expected L2 requests, writeback
// beats and refill beats are queued when stimulus is issued and popped when
// the DUT produces them. Inputs are driven on the falling edge, outputs are
// sampled 1 time unit later, well before the next rising edge.
module tb_l1_miss_arbiter;
    import cache_arb_pkg::*;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int BLOCK_BYTES = 128;
    localparam int BEATS       = calc_beats(BLOCK_BYTES, DATA_W);
    localparam int BEAT_W      = calc_beat_w(BEATS);

    typedef struct { logic write; logic [31:0] addr; owner_t owner; } req_t;
    typedef struct { owner_t owner; logic [31:0] data; logic last; } rsp_t;
    typedef struct { logic [31:0] data; logic last; } wd_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l1_miss_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLOCK_BYTES(BLOCK_BYTES)) bus ();

    l1_miss_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLOCK_BYTES(BLOCK_BYTES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    req_t   exp_req[$];
    rsp_t   exp_rsp[$];
    wd_t    exp_wd[$];
    owner_t grant_log[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // L1 request drivers
    logic        i_pend, d_pend, d_wb;
    logic [31:0] i_addr, d_addr, d_wb_addr;
    // L2 model
    int          req_delay, req_wait, rd_left;
    logic        wready_toggle, wready_phase;
    owner_t      rd_owner;
    // D-cache data store model
    logic              st_rd_prev;
    logic [BEAT_W-1:0] st_beat_prev;
    logic [31:0]       victim;
    // stability tracking
    logic        prev_req_stall, prev_req_write;
    logic [31:0] prev_req_addr;
    logic        prev_wd_stall, prev_wd_last;
    logic [31:0] prev_wd_data;
    // statistics
    int grant_cyc, req_cyc, rsp1_cyc, req_hold;
    int rsp_seen, i_rsp_cnt, d_rsp_cnt, wd_cnt;

    function automatic logic [31:0] wb_pat(input logic [31:0] v, input int beat);
        return v ^ (32'hA5A5_0000 + 32'(beat) * 32'h0001_0101);
    endfunction

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & ~32'(BLOCK_BYTES - 1);
    endfunction

    task automatic clear_model();
        i_pend = 0; d_pend = 0; d_wb = 0;
        i_addr = '0; d_addr = '0; d_wb_addr = '0;
        req_delay = 0; req_wait = 0; rd_left = 0;
        wready_toggle = 0; wready_phase = 0; rd_owner = OWN_I;
        st_rd_prev = 0; st_beat_prev = '0; victim = '0;
        prev_req_stall = 0; prev_req_write = 0; prev_req_addr = '0;
        prev_wd_stall = 0; prev_wd_last = 0; prev_wd_data = '0;
        exp_req.delete(); exp_rsp.delete(); exp_wd.delete(); grant_log.delete();
        bus.i_req_valid = 0; bus.i_req_addr = '0;
        bus.d_req_valid = 0; bus.d_req_addr = '0; bus.d_req_wb = 0; bus.d_req_wb_addr = '0;
        bus.d_wb_data = '0; bus.l2_req_ready = 0; bus.l2_wdata_ready = 0;
        bus.l2_rdata_valid = 0; bus.l2_rdata = '0;
    endtask

    task automatic clear_stats();
        grant_cyc = 0; req_cyc = 0; rsp1_cyc = 0; req_hold = 0;
        rsp_seen = 0; i_rsp_cnt = 0; d_rsp_cnt = 0; wd_cnt = 0;
    endtask

    function automatic logic outs_nonzero();
        return |{bus.i_req_ready, bus.i_rsp_valid, bus.i_rsp_data, bus.i_rsp_last,
                 bus.d_req_ready, bus.d_wb_rd, bus.d_wb_beat, bus.d_rsp_valid,
                 bus.d_rsp_data, bus.d_rsp_last, bus.l2_req_valid, bus.l2_req_write,
                 bus.l2_req_addr, bus.l2_wdata_valid, bus.l2_wdata, bus.l2_wdata_last};
    endfunction

    task automatic do_reset();
        rst = 0;
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    // One clock cycle: drive models, then sample and score the DUT.
    task automatic tick();
        req_t   e;
        rsp_t   r;
        wd_t    w;
        owner_t act_own;
        logic [31:0] act_data;
        logic        act_last;
        @(negedge clk);
        cyc++;
        bus.i_req_valid   = i_pend;
        bus.i_req_addr    = i_addr;
        bus.d_req_valid   = d_pend;
        bus.d_req_addr    = d_addr;
        bus.d_req_wb      = d_wb;
        bus.d_req_wb_addr = d_wb_addr;
        bus.l2_req_ready  = bus.l2_req_valid && (req_wait >= req_delay);
        if (wready_toggle) begin
            wready_phase = !wready_phase;
            bus.l2_wdata_ready = wready_phase;
        end else begin
            bus.l2_wdata_ready = 1'b1;
        end
        bus.d_wb_data = st_rd_prev ? wb_pat(victim, int'(st_beat_prev)) : $urandom();
        if (rd_left > 0) begin
            bus.l2_rdata_valid = 1'b1;
            bus.l2_rdata       = $urandom();
            exp_rsp.push_back('{owner: rd_owner, data: bus.l2_rdata, last: (rd_left == 1)});
            rd_left--;
        end else begin
            bus.l2_rdata_valid = 1'b0;
            bus.l2_rdata       = $urandom();
        end
        #1;
        // grants
        if (bus.i_req_ready || bus.d_req_ready) begin
            checks++;
            if (bus.i_req_ready && bus.d_req_ready) begin
                errors++;
                $display("FAIL dual_grant: got both ready, want one");
            end
        end
        if (bus.i_req_valid && bus.i_req_ready) begin
            grant_log.push_back(OWN_I); i_pend = 0; grant_cyc = cyc;
        end
        if (bus.d_req_valid && bus.d_req_ready) begin
            grant_log.push_back(OWN_D); d_pend = 0; grant_cyc = cyc;
        end
        // L2 request channel
        if (prev_req_stall) begin
            checks++;
            if (bus.l2_req_valid !== 1'b1 || bus.l2_req_addr !== prev_req_addr ||
                bus.l2_req_write !== prev_req_write) begin
                errors++;
                $display("FAIL req_hold: got v=%0b a=%h w=%0b, want v=1 a=%h w=%0b",
                         bus.l2_req_valid, bus.l2_req_addr, bus.l2_req_write,
                         prev_req_addr, prev_req_write);
            end
        end
        if (bus.l2_req_valid && bus.l2_req_ready) begin
            checks++;
            if (exp_req.size() == 0) begin
                errors++;
                $display("FAIL req_unexpected: got a=%h w=%0b, want none",
                         bus.l2_req_addr, bus.l2_req_write);
            end else begin
                e = exp_req.pop_front();
                if (bus.l2_req_write !== e.write || bus.l2_req_addr !== e.addr) begin
                    errors++;
                    $display("FAIL req: got a=%h w=%0b, want a=%h w=%0b",
                             bus.l2_req_addr, bus.l2_req_write, e.addr, e.write);
                end
                if (!e.write) begin
                    rd_left  = BEATS;
                    rd_owner = e.owner;
                end
            end
            req_cyc  = cyc;
            req_hold = req_wait;
            req_wait = 0;
        end else if (bus.l2_req_valid) begin
            req_wait++;
        end
        prev_req_stall = bus.l2_req_valid && !bus.l2_req_ready;
        prev_req_addr  = bus.l2_req_addr;
        prev_req_write = bus.l2_req_write;
        // writeback data channel
        if (prev_wd_stall) begin
            checks++;
            if (bus.l2_wdata_valid !== 1'b1 || bus.l2_wdata !== prev_wd_data ||
                bus.l2_wdata_last !== prev_wd_last) begin
                errors++;
                $display("FAIL wdata_hold: got v=%0b d=%h, want v=1 d=%h",
                         bus.l2_wdata_valid, bus.l2_wdata, prev_wd_data);
            end
        end
        if (bus.l2_wdata_valid && bus.l2_wdata_ready) begin
            checks++;
            wd_cnt++;
            if (exp_wd.size() == 0) begin
                errors++;
                $display("FAIL wdata_unexpected: got d=%h, want none", bus.l2_wdata);
            end else begin
                w = exp_wd.pop_front();
                if (bus.l2_wdata !== w.data || bus.l2_wdata_last !== w.last) begin
                    errors++;
                    $display("FAIL wdata: got d=%h last=%0b, want d=%h last=%0b",
                             bus.l2_wdata, bus.l2_wdata_last, w.data, w.last);
                end
            end
        end
        prev_wd_stall = bus.l2_wdata_valid && !bus.l2_wdata_ready;
        prev_wd_data  = bus.l2_wdata;
        prev_wd_last  = bus.l2_wdata_last;
        // refill responses
        if (bus.i_rsp_valid || bus.d_rsp_valid) begin
            checks++;
            rsp_seen++;
            if (rsp_seen == 1) rsp1_cyc = cyc;
            if (bus.i_rsp_valid) i_rsp_cnt++;
            if (bus.d_rsp_valid) d_rsp_cnt++;
            act_own  = bus.d_rsp_valid ? OWN_D : OWN_I;
            act_data = bus.d_rsp_valid ? bus.d_rsp_data : bus.i_rsp_data;
            act_last = bus.d_rsp_valid ? bus.d_rsp_last : bus.i_rsp_last;
            if (exp_rsp.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got owner=%0d d=%h, want none", act_own, act_data);
            end else begin
                r = exp_rsp.pop_front();
                if ((bus.i_rsp_valid && bus.d_rsp_valid) || act_own !== r.owner ||
                    act_data !== r.data || act_last !== r.last) begin
                    errors++;
                    $display("FAIL rsp: got own=%0d d=%h last=%0b both=%0b, want own=%0d d=%h last=%0b",
                             act_own, act_data, act_last, bus.i_rsp_valid && bus.d_rsp_valid,
                             r.owner, r.data, r.last);
                end
            end
        end else if (bus.l2_rdata_valid) begin
            checks++;
            errors++;
            $display("FAIL rsp_missing: got no rsp_valid, want forwarded beat");
            if (exp_rsp.size() != 0) void'(exp_rsp.pop_front());
        end
        // data-store model: answer one cycle after the strobe
        st_rd_prev   = bus.d_wb_rd;
        st_beat_prev = bus.d_wb_beat;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done;
        for (int n = 0; n < budget; n++) begin
            done = !i_pend && !d_pend && exp_req.size() == 0 && exp_wd.size() == 0 &&
                   rd_left == 0 && exp_rsp.size() == 0;
            if (done) break;
            tick();
        end
        done = !i_pend && !d_pend && exp_req.size() == 0 && exp_wd.size() == 0 &&
               rd_left == 0 && exp_rsp.size() == 0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: got pending work after %0d cycles, want idle", name, budget);
        end
    endtask

    task automatic expect_eq(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic push_wb(input logic [31:0] v);
        exp_req.push_back('{write: 1'b1, addr: align(v), owner: OWN_D});
        for (int b = 0; b < BEATS; b++) begin
            exp_wd.push_back('{data: wb_pat(v, b), last: (b == BEATS - 1)});
        end
    endtask

    task automatic push_rd(input owner_t o, input logic [31:0] a);
        exp_req.push_back('{write: 1'b0, addr: align(a), owner: o});
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        expect_eq("reset_outputs", int'(outs_nonzero()), 0);
        tick();
        expect_eq("idle_outputs", int'(outs_nonzero()), 0);
    endtask

    task automatic test_i_miss();
        clear_stats();
        push_rd(OWN_I, 32'h0000_1234);
        i_pend = 1; i_addr = 32'h0000_1234;
        wait_idle("i_miss", 100);
        expect_eq("i_miss_i_beats", i_rsp_cnt, BEATS);
        expect_eq("i_miss_d_beats", d_rsp_cnt, 0);
        expect_eq("i_miss_req_latency", req_cyc - grant_cyc, 1);
        expect_eq("i_miss_rsp_latency", rsp1_cyc - grant_cyc, 2);
    endtask

    task automatic test_d_writeback();
        clear_stats();
        victim = 32'h0000_8080;
        push_wb(victim);
        push_rd(OWN_D, 32'h0000_5A44);
        d_pend = 1; d_addr = 32'h0000_5A44; d_wb = 1; d_wb_addr = victim;
        wait_idle("d_wb", 200);
        d_wb = 0;
        expect_eq("d_wb_beats", wd_cnt, BEATS);
        expect_eq("d_wb_refill", d_rsp_cnt, BEATS);
        expect_eq("d_wb_i_beats", i_rsp_cnt, 0);
    endtask

    task automatic test_wb_toggle();
        clear_stats();
        wready_toggle = 1;
        victim = 32'h0001_3F00;
        push_wb(victim);
        push_rd(OWN_D, 32'h0002_0000);
        d_pend = 1; d_addr = 32'h0002_0000; d_wb = 1; d_wb_addr = victim;
        wait_idle("wb_toggle", 300);
        d_wb = 0;
        wready_toggle = 0;
        expect_eq("wb_toggle_beats", wd_cnt, BEATS);
        expect_eq("wb_toggle_refill", d_rsp_cnt, BEATS);
    endtask

    task automatic test_req_delay();
        clear_stats();
        req_delay = 5;
        push_rd(OWN_I, 32'h0000_ABCD);
        i_pend = 1; i_addr = 32'h0000_ABCD;
        wait_idle("req_delay", 150);
        req_delay = 0;
        expect_eq("req_delay_hold", req_hold, 5);
        expect_eq("req_delay_beats", i_rsp_cnt, BEATS);
    endtask

    task automatic test_reset_mid();
        clear_stats();
        push_rd(OWN_I, 32'h0000_7700);
        i_pend = 1; i_addr = 32'h0000_7700;
        for (int n = 0; n < 100 && rsp_seen < 10; n++) tick();
        expect_eq("mid_reached_beat10", rsp_seen, 10);
        rst = 0;
        clear_model();
        #1;
        expect_eq("mid_reset_async", int'(outs_nonzero()), 0);
        @(posedge clk);
        #1;
        expect_eq("mid_reset_edge", int'(outs_nonzero()), 0);
        @(negedge clk);
        rst = 1;
        clear_stats();
        push_rd(OWN_I, 32'h0000_0F00);
        i_pend = 1; i_addr = 32'h0000_0F00;
        wait_idle("post_reset", 100);
        expect_eq("post_reset_beats", i_rsp_cnt, BEATS);
    endtask

    task automatic test_arbitration();
        owner_t want[3];
        do_reset();
        clear_stats();
        push_rd(OWN_D, 32'h2000_0010);
`ifdef ARB_ROUND_ROBIN_EN
        push_rd(OWN_I, 32'h3000_0044);
        push_rd(OWN_D, 32'h4000_00FF);
        want = '{OWN_D, OWN_I, OWN_D};
`else
        push_rd(OWN_D, 32'h4000_00FF);
        push_rd(OWN_I, 32'h3000_0044);
        want = '{OWN_D, OWN_D, OWN_I};
`endif
        i_pend = 1; i_addr = 32'h3000_0044;
        d_pend = 1; d_addr = 32'h2000_0010;
        for (int n = 0; n < 10 && grant_log.size() == 0; n++) tick();
        expect_eq("arb_first_grant_seen", grant_log.size(), 1);
        d_pend = 1; d_addr = 32'h4000_00FF;
        wait_idle("arb", 300);
        expect_eq("arb_grant_count", grant_log.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < grant_log.size()) expect_eq($sformatf("arb_grant%0d", k), int'(grant_log[k]), int'(want[k]));
        end
    endtask

    initial begin
        clear_model();
        clear_stats();
        test_reset();
        test_i_miss();
        test_d_writeback();
        test_wb_toggle();
        test_req_delay();
        test_reset_mid();
        test_arbitration();
        repeat (2) tick();
        expect_eq("queues_drained", exp_req.size() + exp_wd.size() + exp_rsp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
